// File: rtl/io_bridge_pkg.sv
// Shared definitions for the CPU I/O bridge: peripheral address map, access
// select codes and active-low seven-segment patterns ({dp,g..a}).
package io_bridge_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;

    localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DRAM,
        SEL_DIG,
        SEL_TCNT,
        SEL_TDIV,
        SEL_LED,
        SEL_SW,
        SEL_BTN
    } sel_t;

    // Everything below the peripheral page is DRAM; inside it only exact
    // register addresses hit, anything else is an unmapped hole.
    function automatic sel_t decode_sel(input logic [31:0] addr);
        sel_t sel;
        if (addr[31:12] != PERIPH_BASE[31:12]) begin
            sel = SEL_DRAM;
        end else begin
            case (addr)
                ADDR_DIG:  sel = SEL_DIG;
                ADDR_TCNT: sel = SEL_TCNT;
                ADDR_TDIV: sel = SEL_TDIV;
                ADDR_LED:  sel = SEL_LED;
                ADDR_SW:   sel = SEL_SW;
                ADDR_BTN:  sel = SEL_BTN;
                default:   sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_bridge_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern, decimal point always off.
module io_bridge_seg_decoder
    import io_bridge_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/io_bridge.sv
// MEM-stage bus bridge: routes each single-cycle access to DRAM or to the
// board peripherals (LEDs, switches, buttons, 7-seg display, timer).
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int          DRAM_AW  = 16,
    parameter int          SCAN_DIV = 20000,
    parameter logic [31:0] TDIV_RST = 32'd25000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         seg_en,
    output logic [7:0]         seg_dn
);

    localparam int              SCW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_DIV - 1);

    sel_t        sel;
    logic        wr_dig;
    logic        wr_tcnt;
    logic        wr_tdiv;
    logic        wr_led;
    logic        tick;

    logic [31:0] dig;
    logic [31:0] tcnt;
    logic [31:0] tdiv;
    logic [31:0] pcnt;
    logic [23:0] sw_meta;
    logic [23:0] sw_sync;
    logic [4:0]  btn_meta;
    logic [4:0]  btn_sync;
    logic [SCW-1:0] scan_cnt;
    logic [2:0]  idx;
    logic [7:0]  seg_pat;

    assign sel        = decode_sel(Bus_addr);
    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = Bus_wen & (sel == SEL_DRAM);
    assign dram_wdata = Bus_wdata;

    assign wr_dig  = Bus_wen & (sel == SEL_DIG);
    assign wr_tcnt = Bus_wen & (sel == SEL_TCNT);
    assign wr_tdiv = Bus_wen & (sel == SEL_TDIV);
    assign wr_led  = Bus_wen & (sel == SEL_LED);

    // The core samples read data in the same cycle, so this path stays combinational.
    always_comb begin
        Bus_rdata = '0;
        case (sel)
            SEL_DRAM: Bus_rdata = dram_rdata;
            SEL_DIG:  Bus_rdata = dig;
            SEL_TCNT: Bus_rdata = tcnt;
            SEL_TDIV: Bus_rdata = tdiv;
            SEL_LED:  Bus_rdata = {8'h00, led};
            SEL_SW:   Bus_rdata = {8'h00, sw_sync};
            SEL_BTN:  Bus_rdata = {27'h0, btn_sync};
            default:  Bus_rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            led <= '0;
            dig <= '0;
        end else begin
            if (wr_led) led <= Bus_wdata[23:0];
            if (wr_dig) dig <= Bus_wdata;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    assign tick = (tdiv != 32'd0) && (pcnt == tdiv - 32'd1);

    // A TCNT write takes priority over a tick landing in the same cycle.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            tcnt <= '0;
            tdiv <= TDIV_RST;
            pcnt <= '0;
        end else begin
            if (wr_tcnt)   tcnt <= Bus_wdata;
            else if (tick) tcnt <= tcnt + 32'd1;

            if (wr_tdiv) tdiv <= Bus_wdata;

            if (wr_tcnt || wr_tdiv || tick || (tdiv == 32'd0)) pcnt <= '0;
            else                                               pcnt <= pcnt + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    io_bridge_seg_decoder u_seg_decoder (
        .hex (dig[{idx, 2'b00} +: 4]),
        .seg (seg_pat)
    );

    // Digit drive is registered so the pads see glitch-free enables.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            seg_en <= 8'hFE;
            seg_dn <= SEG_0;
        end else begin
            seg_en <= ~(8'd1 << idx);
            seg_dn <= seg_pat;
        end
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Sits directly downstream of the CPU core's MEM stage, on the Bus_* interface.
- Decodes each bus access and routes it either to DRAM or to the on-board peripherals: LEDs, switches, buttons, an 8-digit seven-segment display and a free-running timer.
- Reads are combinational within the MEM cycle, because the core samples Bus_rdata in the same cycle.
- Writes commit on the rising edge of cpu_clk.

Parameters:
- DRAM_AW, 16: DRAM word-address width; dram_addr = Bus_addr[DRAM_AW+1:2].
- SCAN_DIV, 20000: cpu_clk cycles per seven-segment digit slot.
- TDIV_RST, 32'd25000: reset value of the timer divider register.

Ports:
- cpu_clk  in  1  system clock
- cpu_rst  in  1  reset (asynchronous, active-high)
- Bus_addr  in  32  byte address from the core
- Bus_wen  in  1  write enable from the core
- Bus_wdata  in  32  write data from the core
- Bus_rdata  out  32  read data to the core (combinational)
- dram_addr  out  DRAM_AW  DRAM word address
- dram_we  out  1  DRAM write enable
- dram_wdata  out  32  DRAM write data
- dram_rdata  in  32  DRAM read data (asynchronous read)
- sw  in  24  board switches (asynchronous)
- btn  in  5  board buttons (asynchronous)
- led  out  24  board LEDs
- seg_en  out  8  digit enables, active-low
- seg_dn  out  8  segments {dp,g..a}, active-low

Behaviour:
- Address map (exact compare on Bus_addr):
  - DIG 0xFFFF_F000: RW, display value.
  - TCNT 0xFFFF_F020: RW, timer count.
  - TDIV 0xFFFF_F024: RW, timer divider.
  - LED 0xFFFF_F060: RW, LED[23:0].
  - SW 0xFFFF_F070: RO, switches.
  - BTN 0xFFFF_F078: RO, buttons.
  - Any other 0xFFFF_Fxxx address: unmapped peripheral; reads 0, writes ignored.
  - Every address below 0xFFFF_F000: DRAM.
- DRAM path:
  - dram_we = Bus_wen & is_dram.
  - dram_wdata = Bus_wdata.
  - Bus_rdata = dram_rdata when is_dram.
- Peripheral writes: registered on cpu_clk when Bus_wen & address hit. Writes to SW/BTN are ignored.
- Peripheral reads:
  - Combinational, zero-extended.
  - SW and BTN return the 2-flop-synchronised input, so an input change is visible 2 cycles later.
- Reset values:
  - led = 0, DIG = 0, TCNT = 0, TDIV = TDIV_RST.
  - Scan counter = 0, digit index = 0.
  - Synchronisers = 0.
  - seg_en = 8'hFE (digit 0 selected); seg_dn = pattern for 0.
- Timer:
  - Prescaler pcnt increments each cycle.
  - When pcnt == TDIV-1: pcnt <= 0 and TCNT <= TCNT+1. TCNT wraps 0xFFFF_FFFF -> 0.
  - TDIV == 0: timer frozen; pcnt held at 0.
  - Write to TCNT: TCNT <= Bus_wdata and pcnt <= 0. This overrides a tick in the same cycle.
  - Write to TDIV: TDIV <= Bus_wdata and pcnt <= 0.
- Display scan:
  - scan counter counts 0..SCAN_DIV-1. On wrap, digit index advances 0..7 and wraps to 0.
  - seg_en = ~(1 << idx).
  - seg_dn = decode of DIG[4*idx+3:4*idx], hex 0-F, dp off.
  - Outputs are registered, i.e. one cycle after idx changes.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous). A write pending in that cycle is lost.
- No stalls and no handshake: the bridge always completes an access in a single cycle.

Decomposition:
- Shared package: address constants (DIG, TCNT, TDIV, LED, SW, BTN), the peripheral base 0xFFFF_F000, and the seven-segment pattern constants.
- One sub-module, seg_decoder: combinational 4-bit hex -> 8-bit active-low segment pattern.
- All other logic stays in io_bridge.

Test Plan:
1. DRAM write then read:
   - Stimulus: Bus_addr=0x0000_0100, Bus_wen=1, Bus_wdata=0xDEADBEEF.
   - Required: dram_we=1 and dram_addr=0x40; on a later read, Bus_rdata=0xDEADBEEF.
   - Also: the same write to 0xFFFF_F060 gives dram_we=0.
2. LED write/readback:
   - Stimulus: write 0x00A5_5A5A to 0xFFFF_F060.
   - Required: led=0xA55A5A the next cycle; a read returns 0x00A5_5A5A; an unmapped 0xFFFF_F010 read returns 0.
3. Switch sync:
   - Stimulus: sw=0x123456 applied.
   - Required: a read of 0xFFFF_F070 returns 0 for 2 cycles, then 0x0012_3456.
4. Timer:
   - Stimulus: TDIV=4, TCNT=0xFFFF_FFFE.
   - Required: TCNT reads 0xFFFF_FFFF after 4 cycles, then 0 after 4 more.
   - Also: with TDIV=0, TCNT stays constant for 100 cycles.
   - Also: a TCNT write coinciding with a tick leaves TCNT equal to the written value.
5. Display:
   - Stimulus: SCAN_DIV=4, DIG=0x89AB_CDEF.
   - Required: seg_en cycles FE, FD, ..., 7F with 4 cycles per slot; digit 0 shows F (seg_dn=8'h8E), digit 7 shows 8 (8'h80).
6. Async reset mid-scan:
   - Stimulus: assert cpu_rst between clock edges.
   - Required: led=0, seg_en=8'hFE and TDIV=TDIV_RST immediately, before the next edge.
